// File: rtl/yari_pkg.sv
// ---------------------------------------------------------------------------
// yari_pkg
// Shared definitions for the YARI MIPS pipeline: register-index width,
// opcode / function / REGIMM constants, the operand-2 source selector and
// small opcode-class helpers used by the decode stage.
// ---------------------------------------------------------------------------
package yari_pkg;

  // Register index width (64 architectural/extended entries).
  localparam int REG_W    = 6;
  localparam int RF_DEPTH = 64;

  // Primary opcodes.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;  // first load opcode
  localparam logic [5:0] OP_LWR     = 6'h26;  // last load opcode
  localparam logic [5:0] OP_SB      = 6'h28;  // first store opcode
  localparam logic [5:0] OP_SWR     = 6'h2E;  // last store opcode

  // SPECIAL function codes.
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  // REGIMM rt codes that link.
  localparam logic [4:0] RI_BLTZAL  = 5'h10;
  localparam logic [4:0] RI_BGEZAL  = 5'h11;

  // Link register.
  localparam logic [REG_W-1:0] REG_RA = 6'd31;

  // Source of the second ALU operand.
  typedef enum logic [1:0] {
    OP2_RT   = 2'd0,
    OP2_ZIMM = 2'd1,
    OP2_SIMM = 2'd2
  } op2_sel_e;

  // Loads occupy opcodes 0x20..0x26.
  function automatic logic is_load_op(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_LWR);
  endfunction

  // Stores occupy opcodes 0x28..0x2E.
  function automatic logic is_store_op(input logic [5:0] op);
    return (op >= OP_SB) && (op <= OP_SWR);
  endfunction

  // Immediate ALU ops occupy opcodes 0x08..0x0F.
  function automatic logic is_imm_alu_op(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

  // ANDI/ORI/XORI zero-extend their immediate.
  function automatic logic is_logic_imm_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/yari_regfile.sv
// ---------------------------------------------------------------------------
// yari_regfile
// 64 x 32 register file: one synchronous write port, two asynchronous read
// ports. Entry 0 is never written. Contents are not reset.
// Ports:
//   clock              rising-edge clock
//   we, waddr, wdata   write port (write happens at the clock edge)
//   raddr_a / rdata_a  asynchronous read port A
//   raddr_b / rdata_b  asynchronous read port B
// ---------------------------------------------------------------------------
module yari_regfile
  import yari_pkg::*;
(
  input  logic             clock,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [REG_W-1:0] raddr_a,
  output logic [31:0]      rdata_a,
  input  logic [REG_W-1:0] raddr_b,
  output logic [31:0]      rdata_b
);

  logic [31:0] mem_r [0:RF_DEPTH-1];

  // Write port; entry 0 is hard-wired to discard writes.
  always_ff @(posedge clock) begin
    if (we && (waddr != {REG_W{1'b0}})) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/stage_d.sv
// ---------------------------------------------------------------------------
// stage_d
// Decode stage of the 5-stage YARI MIPS pipeline (I->D->X->M->W).
// Latches the fetched instruction, decodes its fields, reads operands from
// the register file with X/M bypassing, and detects load-use hazards,
// requesting a restart that stage X performs.
//
// Ports:
//   clock, rst                   clock (rising edge), async active-low reset
//   i_valid/i_instr/i_pc/i_npc   fetched instruction
//   x_valid/x_wbr/x_res          X-stage result for bypassing
//   m_valid/m_wbr/m_res/m_pc     M-stage writeback (m_pc for trace only)
//   flush_D                      kill the D instruction before it enters X
//   d_*                          decoded fields, operand values, hazard
//                                restart request
//
// Configuration:
//   STAGE_D_TRACE_EN  when defined, prints a per-cycle trace of the decoded
//                     instruction and of register-file writes.
// ---------------------------------------------------------------------------
module stage_d
  import yari_pkg::*;
(
  input  logic             clock,
  input  logic             rst,

  input  logic             i_valid,
  input  logic [31:0]      i_instr,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_npc,

  input  logic             x_valid,
  input  logic [REG_W-1:0] x_wbr,
  input  logic [31:0]      x_res,

  input  logic             m_valid,
  input  logic [REG_W-1:0] m_wbr,
  input  logic [31:0]      m_res,
  input  logic [31:0]      m_pc,

  input  logic             flush_D,

  output logic             d_valid,
  output logic [31:0]      d_instr,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_npc,
  output logic [5:0]       d_opcode,
  output logic [5:0]       d_fn,
  output logic [4:0]       d_rd,
  output logic [4:0]       d_sa,
  output logic [REG_W-1:0] d_rs,
  output logic [REG_W-1:0] d_rt,
  output logic [31:0]      d_target,
  output logic [31:0]      d_simm,
  output logic [REG_W-1:0] d_wbr,
  output logic             d_has_delay_slot,
  output logic [31:0]      d_op1_val,
  output logic [31:0]      d_op2_val,
  output logic [31:0]      d_rt_val,
  output logic             d_restart,
  output logic [31:0]      d_restart_pc,
  output logic             d_flush_X
);

  // Hazard-tracking state describing the instruction that entered X.
  logic             prev_load_r;
  logic [REG_W-1:0] prev_wbr_r;
  logic             prev_dslot_r;
  logic [31:0]      prev_pc_r;

  logic [31:0]      rf_rs_s;
  logic [31:0]      rf_rt_s;
  logic [31:0]      rs_val_s;
  logic [31:0]      zimm_s;
  op2_sel_e         op2_sel_s;
  logic             is_load_s;
  logic             carry_s;

  // Operand value with bypass: r0 is zero, X beats M, M beats the file.
  function automatic logic [31:0] fwd_val(
    input logic [REG_W-1:0] r,
    input logic             xv,
    input logic [REG_W-1:0] xw,
    input logic [31:0]      xr,
    input logic             mv,
    input logic [REG_W-1:0] mw,
    input logic [31:0]      mr,
    input logic [31:0]      rf
  );
    logic [31:0] v;
    if (r == {REG_W{1'b0}}) begin
      v = 32'h0000_0000;
    end else if (xv && (xw == r)) begin
      v = xr;
    end else if (mv && (mw == r)) begin
      v = mr;
    end else begin
      v = rf;
    end
    return v;
  endfunction

  // Pipeline latch of the fetched instruction.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      d_valid <= 1'b0;
      d_instr <= 32'h0000_0000;
      d_pc    <= 32'h0000_0000;
      d_npc   <= 32'h0000_0000;
    end else begin
      d_valid <= i_valid;
      d_instr <= i_instr;
      d_pc    <= i_pc;
      d_npc   <= i_npc;
    end
  end

  // Field extraction.
  assign d_opcode = d_instr[31:26];
  assign d_fn     = d_instr[5:0];
  assign d_rd     = d_instr[15:11];
  assign d_sa     = d_instr[10:6];
  assign d_rs     = {1'b0, d_instr[25:21]};
  assign d_rt     = {1'b0, d_instr[20:16]};
  assign d_target = {d_npc[31:28], d_instr[25:0], 2'b00};
  assign d_simm   = {{16{d_instr[15]}}, d_instr[15:0]};
  assign zimm_s   = {16'h0000, d_instr[15:0]};
  assign is_load_s = is_load_op(d_opcode);

  // Destination register, delay-slot flag and operand-2 source.
  always_comb begin
    d_wbr            = {REG_W{1'b0}};
    d_has_delay_slot = 1'b0;
    op2_sel_s        = OP2_RT;
    case (d_opcode)
      OP_SPECIAL: begin
        if (d_fn == FN_JR) begin
          d_wbr = {REG_W{1'b0}};
        end else begin
          d_wbr = {1'b0, d_rd};
        end
        if ((d_fn == FN_JR) || (d_fn == FN_JALR)) begin
          d_has_delay_slot = 1'b1;
        end else begin
          d_has_delay_slot = 1'b0;
        end
      end
      OP_REGIMM: begin
        d_has_delay_slot = 1'b1;
        if ((d_rt[4:0] == RI_BLTZAL) || (d_rt[4:0] == RI_BGEZAL)) begin
          d_wbr = REG_RA;
        end else begin
          d_wbr = {REG_W{1'b0}};
        end
      end
      OP_J: begin
        d_has_delay_slot = 1'b1;
      end
      OP_JAL: begin
        d_has_delay_slot = 1'b1;
        d_wbr            = REG_RA;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        d_has_delay_slot = 1'b1;
      end
      OP_COP0: begin
        // Only MFC0 (rs field 0) writes a GPR.
        if (d_rs == {REG_W{1'b0}}) begin
          d_wbr = d_rt;
        end else begin
          d_wbr = {REG_W{1'b0}};
        end
      end
      default: begin
        if (is_imm_alu_op(d_opcode)) begin
          d_wbr = d_rt;
          if (is_logic_imm_op(d_opcode)) begin
            op2_sel_s = OP2_ZIMM;
          end else begin
            op2_sel_s = OP2_SIMM;
          end
        end else if (is_load_s) begin
          d_wbr     = d_rt;
          op2_sel_s = OP2_SIMM;
        end else if (is_store_op(d_opcode)) begin
          op2_sel_s = OP2_SIMM;
        end else begin
          op2_sel_s = OP2_RT;
        end
      end
    endcase
  end

  yari_regfile u_regfile (
    .clock   (clock),
    .we      (m_valid),
    .waddr   (m_wbr),
    .wdata   (m_res),
    .raddr_a (d_rs),
    .rdata_a (rf_rs_s),
    .raddr_b (d_rt),
    .rdata_b (rf_rt_s)
  );

  // Bypassed operand values.
  always_comb begin
    rs_val_s  = fwd_val(d_rs, x_valid, x_wbr, x_res, m_valid, m_wbr, m_res, rf_rs_s);
    d_rt_val  = fwd_val(d_rt, x_valid, x_wbr, x_res, m_valid, m_wbr, m_res, rf_rt_s);
    d_op1_val = rs_val_s;
    case (op2_sel_s)
      OP2_ZIMM: d_op2_val = zimm_s;
      OP2_SIMM: d_op2_val = d_simm;
      OP2_RT:   d_op2_val = d_rt_val;
      default:  d_op2_val = d_rt_val;
    endcase
  end

  // Load-use hazard: restart the consumer; a delay slot restarts from its
  // branch, and the branch sitting in X is killed.
  assign d_restart    = d_valid && prev_load_r && (prev_wbr_r != {REG_W{1'b0}}) &&
                        ((d_rs == prev_wbr_r) || (d_rt == prev_wbr_r));
  assign d_restart_pc = prev_dslot_r ? prev_pc_r : d_pc;
  assign d_flush_X    = d_restart && prev_dslot_r;

  // A branch following a load keeps the load pending, so that a delay slot
  // consuming the load restarts together with its branch.
  assign carry_s = d_has_delay_slot && prev_load_r && !is_load_s;

  // Hazard-tracking state for the instruction entering X.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      prev_load_r  <= 1'b0;
      prev_wbr_r   <= {REG_W{1'b0}};
      prev_dslot_r <= 1'b0;
      prev_pc_r    <= 32'h0000_0000;
    end else if (d_valid && !flush_D && !d_restart) begin
      prev_load_r  <= is_load_s || carry_s;
      prev_wbr_r   <= carry_s ? prev_wbr_r : d_wbr;
      prev_dslot_r <= d_has_delay_slot;
      prev_pc_r    <= d_pc;
    end else begin
      prev_load_r  <= 1'b0;
      prev_wbr_r   <= prev_wbr_r;
      prev_dslot_r <= prev_dslot_r;
      prev_pc_r    <= prev_pc_r;
    end
  end

`ifdef STAGE_D_TRACE_EN
  // Simulation trace of decode and register-file writes.
  always_ff @(posedge clock) begin
    if (d_valid) begin
      $display("%0t D pc=%h instr=%h wbr=%0d restart=%0b",
               $time, d_pc, d_instr, d_wbr, d_restart);
    end
    if (m_valid && (m_wbr != {REG_W{1'b0}})) begin
      $display("%0t RF r%0d <= %h (pc=%h)", $time, m_wbr, m_res, m_pc);
    end
  end
`else
  // m_pc is only consumed by the trace.
  logic unused_m_pc_s;
  assign unused_m_pc_s = ^m_pc;
`endif

endmodule

// File: tb/tb_stage_d.sv
// ---------------------------------------------------------------------------
// tb_stage_d
// Self-checking bench for stage_d. Expected values are pushed to a
// scoreboard when an instruction is driven and popped/compared once the
// instruction sits in D.
// ---------------------------------------------------------------------------
module tb_stage_d;

  logic        clock = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_instr, i_pc, i_npc;
  logic        x_valid;
  logic [5:0]  x_wbr;
  logic [31:0] x_res;
  logic        m_valid;
  logic [5:0]  m_wbr;
  logic [31:0] m_res, m_pc;
  logic        flush_D;

  logic        d_valid;
  logic [31:0] d_instr, d_pc, d_npc;
  logic [5:0]  d_opcode, d_fn;
  logic [4:0]  d_rd, d_sa;
  logic [5:0]  d_rs, d_rt;
  logic [31:0] d_target, d_simm;
  logic [5:0]  d_wbr;
  logic        d_has_delay_slot;
  logic [31:0] d_op1_val, d_op2_val, d_rt_val;
  logic        d_restart;
  logic [31:0] d_restart_pc;
  logic        d_flush_X;

  int vec_cnt = 0;
  int err_cnt = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  stage_d dut (
    .clock(clock), .rst(rst),
    .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc), .i_npc(i_npc),
    .x_valid(x_valid), .x_wbr(x_wbr), .x_res(x_res),
    .m_valid(m_valid), .m_wbr(m_wbr), .m_res(m_res), .m_pc(m_pc),
    .flush_D(flush_D),
    .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_npc(d_npc),
    .d_opcode(d_opcode), .d_fn(d_fn), .d_rd(d_rd), .d_sa(d_sa),
    .d_rs(d_rs), .d_rt(d_rt), .d_target(d_target), .d_simm(d_simm),
    .d_wbr(d_wbr), .d_has_delay_slot(d_has_delay_slot),
    .d_op1_val(d_op1_val), .d_op2_val(d_op2_val), .d_rt_val(d_rt_val),
    .d_restart(d_restart), .d_restart_pc(d_restart_pc), .d_flush_X(d_flush_X)
  );

  always #5 clock = ~clock;

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] observe(input string tag);
    logic [31:0] v;
    v = 32'hxxxx_xxxx;
    if      (tag == "valid")   v = {31'd0, d_valid};
    else if (tag == "pc")      v = d_pc;
    else if (tag == "instr")   v = d_instr;
    else if (tag == "npc")     v = d_npc;
    else if (tag == "opcode")  v = {26'd0, d_opcode};
    else if (tag == "fn")      v = {26'd0, d_fn};
    else if (tag == "rd")      v = {27'd0, d_rd};
    else if (tag == "rs")      v = {26'd0, d_rs};
    else if (tag == "rt")      v = {26'd0, d_rt};
    else if (tag == "target")  v = d_target;
    else if (tag == "simm")    v = d_simm;
    else if (tag == "wbr")     v = {26'd0, d_wbr};
    else if (tag == "dslot")   v = {31'd0, d_has_delay_slot};
    else if (tag == "op1")     v = d_op1_val;
    else if (tag == "op2")     v = d_op2_val;
    else if (tag == "rtval")   v = d_rt_val;
    else if (tag == "restart") v = {31'd0, d_restart};
    else if (tag == "rpc")     v = d_restart_pc;
    else if (tag == "flushx")  v = {31'd0, d_flush_X};
    return v;
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic drain();
    string       t;
    logic [31:0] v;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      v = exp_q.pop_front();
      check_val(t, observe(t), v);
    end
  endtask

  // Present an instruction at the falling edge; returns #1 after it is in D.
  // kill_cur flushes the instruction currently in D.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic kill_cur);
    @(negedge clock);
    i_valid = 1'b1;
    i_instr = instr;
    i_pc    = pc;
    i_npc   = pc + 32'd4;
    x_valid = 1'b0;
    m_valid = 1'b0;
    flush_D = kill_cur;
    @(posedge clock);
    #1;
    flush_D = 1'b0;
  endtask

  // Write a register through the M-stage port during a bubble cycle.
  task automatic wr_reg(input logic [5:0] r, input logic [31:0] v);
    @(negedge clock);
    i_valid = 1'b0;
    x_valid = 1'b0;
    flush_D = 1'b0;
    m_valid = 1'b1;
    m_wbr   = r;
    m_res   = v;
    m_pc    = 32'h0000_1000;
    @(posedge clock);
    #1;
    m_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 1'b0; i_instr = 32'h0; i_pc = 32'h0; i_npc = 32'h0;
    x_valid = 1'b0; x_wbr = 6'd0; x_res = 32'h0;
    m_valid = 1'b0; m_wbr = 6'd0; m_res = 32'h0; m_pc = 32'h0;
    flush_D = 1'b0;

    // Reset state.
    #12;
    push("valid", 32'd0); push("restart", 32'd0); push("flushx", 32'd0);
    push("pc", 32'd0); push("instr", 32'd0);
    drain();
    @(negedge clock);
    rst = 1'b1;

    // ADDIU r2,r1,-1 with r1 = 5.
    wr_reg(6'd1, 32'd5);
    issue(32'h2422_FFFF, 32'h0000_0100, 1'b0);
    push("valid", 32'd1); push("op1", 32'd5); push("op2", 32'hFFFF_FFFF);
    push("wbr", 32'd2); push("rs", 32'd1); push("rt", 32'd2);
    push("simm", 32'hFFFF_FFFF); push("dslot", 32'd0); push("restart", 32'd0);
    push("npc", 32'h0000_0104);
    drain();

    // ADDU r6,r3,r0: X beats M, then M alone.
    issue(32'h0060_3021, 32'h0000_0104, 1'b0);
    x_valid = 1'b1; x_wbr = 6'd3; x_res = 32'd7;
    m_valid = 1'b1; m_wbr = 6'd3; m_res = 32'd9;
    #1;
    push("op1", 32'd7); push("op2", 32'd0); push("wbr", 32'd6);
    push("fn", 32'h21); push("rd", 32'd6); push("sa", 32'd0); push("opcode", 32'd0);
    drain();
    x_valid = 1'b0;
    #1;
    push("op1", 32'd9);
    drain();

    // ORI zero-extends its immediate.
    issue(32'h3427_8001, 32'h0000_0108, 1'b0);
    push("op1", 32'd5); push("op2", 32'h0000_8001); push("wbr", 32'd7);
    drain();

    // Register file holds a written value: ADDU r8,r3,r1.
    wr_reg(6'd3, 32'd9);
    issue(32'h0061_4021, 32'h0000_010C, 1'b0);
    push("op1", 32'd9); push("op2", 32'd5); push("rtval", 32'd5); push("wbr", 32'd8);
    drain();

    // LW r4,0(r1) ; ADDU r5,r4,r4 -> restart at the ADDU.
    issue(32'h8C24_0000, 32'h0000_0200, 1'b0);
    push("opcode", 32'h23); push("wbr", 32'd4); push("op2", 32'd0); push("restart", 32'd0);
    drain();
    issue(32'h0084_2821, 32'h0000_0204, 1'b0);
    push("restart", 32'd1); push("rpc", 32'h0000_0204); push("flushx", 32'd0);
    drain();
    issue(32'h0084_2821, 32'h0000_0204, 1'b0);
    push("restart", 32'd0);
    drain();

    // LW r4 ; BEQ r1,r2 ; delay slot ADDU r5,r4,r0 -> restart the branch.
    issue(32'h8C24_0000, 32'h0000_0300, 1'b0);
    issue(32'h1022_0004, 32'h0000_0304, 1'b0);
    push("restart", 32'd0); push("dslot", 32'd1); push("wbr", 32'd0);
    drain();
    issue(32'h0080_2821, 32'h0000_0308, 1'b0);
    push("restart", 32'd1); push("rpc", 32'h0000_0304); push("flushx", 32'd1);
    drain();

    // A flushed load creates no hazard.
    issue(32'h8C24_0000, 32'h0000_0400, 1'b0);
    issue(32'h0084_2821, 32'h0000_0404, 1'b1);
    push("restart", 32'd0); push("flushx", 32'd0);
    drain();

    // JAL 0x0040_0010 at 0x8000_0000.
    issue(32'h0C10_0004, 32'h8000_0000, 1'b0);
    push("target", 32'h8040_0010); push("wbr", 32'd31); push("dslot", 32'd1);
    drain();

    // r0 reads as zero under any bypass.
    issue(32'h0000_4821, 32'h8000_0004, 1'b0);
    x_valid = 1'b1; x_wbr = 6'd0; x_res = 32'hDEAD_BEEF;
    m_valid = 1'b1; m_wbr = 6'd0; m_res = 32'hCAFE_F00D;
    #1;
    push("op1", 32'd0); push("rtval", 32'd0); push("wbr", 32'd9);
    drain();

    // Remaining destination / operand-2 classes.
    issue(32'h03E0_0008, 32'h0000_0500, 1'b0);          // JR r31
    push("wbr", 32'd0); push("dslot", 32'd1);
    drain();
    issue(32'h0430_0004, 32'h0000_0504, 1'b0);          // BLTZAL r1
    push("wbr", 32'd31); push("dslot", 32'd1);
    drain();
    issue(32'h3C0A_1234, 32'h0000_0508, 1'b0);          // LUI r10
    push("wbr", 32'd10); push("op2", 32'h0000_1234); push("op1", 32'd0);
    drain();
    issue(32'h400B_6000, 32'h0000_050C, 1'b0);          // MFC0 r11
    push("wbr", 32'd11); push("dslot", 32'd0);
    drain();
    issue(32'h408B_6000, 32'h0000_0510, 1'b0);          // MTC0
    push("wbr", 32'd0);
    drain();
    issue(32'hAC21_FFFC, 32'h0000_0514, 1'b0);          // SW r1,-4(r1)
    push("wbr", 32'd0); push("op1", 32'd5); push("op2", 32'hFFFF_FFFC);
    push("rtval", 32'd5);
    drain();

    // Reset mid-run while a restart is pending.
    issue(32'h8C24_0000, 32'h0000_0600, 1'b0);
    issue(32'h0084_2821, 32'h0000_0604, 1'b0);
    push("restart", 32'd1);
    drain();
    #2;
    rst = 1'b0;
    #1;
    push("valid", 32'd0); push("restart", 32'd0); push("flushx", 32'd0);
    drain();
    @(negedge clock);
    rst = 1'b1;
    i_valid = 1'b1; i_instr = 32'h0000_4821; i_pc = 32'h0000_0700; i_npc = 32'h0000_0704;
    #1;
    push("valid", 32'd0);
    drain();
    @(posedge clock);
    #1;
    push("valid", 32'd1); push("pc", 32'h0000_0700); push("restart", 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
